repl_rr_sched: RTL and testbench

- Round-robin scheduler that shares one replicating output register between N requesters.
- Each requester offers a 1-bit signed sample. The block grants one requester per beat and emits the sample replicated to a width derived from parameters P and Q.
- Sits in front of the parameterised replication datapath and sequences access to it with valid/ready on both sides.

---
 rtl/repl_pkg.sv | 28 ++
 rtl/rr_pick.sv | 33 +++
 rtl/repl_rr_sched.sv | 94 +++++++++
 tb/tb_repl_rr_sched.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/repl_pkg.sv
// Shared sizing helpers and state encoding for the replicating scheduler family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package repl_pkg;

    // Output slot occupancy; the encoding matches out_valid directly.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    // Replicated width: bit 0 of q as a signed 1-bit value, sign-extended to
    // p bits and read back unsigned, plus q itself.
    function automatic int repl_width(input int p, input int q);
        int f;
        f = q[0] ? ((1 << p) - 1) : 0;
        return f + q;
    endfunction

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first valid index after ptr, scanning modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller gates the valid vector or the grant.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_vld
);

    logic [IW-1:0] idx;

    // Scan ptr+1 .. ptr+N (mod N); the first hit wins, so ptr itself is last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (!grant_vld && valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/repl_rr_sched.sv
// Round-robin scheduler feeding one registered output slot that replicates a 1-bit sample to W bits.
// Latency: one cycle from request transfer to out_valid; one beat per cycle sustained.
// Backpressure: out_ready low freezes the slot and forces req_ready to zero; requesters must hold.
module repl_rr_sched
    import repl_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int P  = 2,
    parameter  int Q  = 1,
    localparam int W  = repl_width(P, Q),
    localparam int IW = clog2_min1(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_valid,
    input  logic [N-1:0]  req_data,
    output logic [N-1:0]  req_ready,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    output logic [IW-1:0] out_id,
    input  logic          out_ready,
    output logic          busy
);

    slot_state_e   state_q, state_d;
    logic [W-1:0]  data_q, data_d;
    logic [IW-1:0] id_q, id_d;
    logic [IW-1:0] ptr_q, ptr_d;

    logic [N-1:0]  grant;
    logic [IW-1:0] gnt_idx;
    logic          gnt_vld;
    logic          slot_free;
    logic          xfer;

    // Grant depends only on req_valid and the pointer, never on req_data.
    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .valid     (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (gnt_idx),
        .grant_vld (gnt_vld)
    );

    // Offer the slot when empty or draining this cycle; nothing is offered during reset.
    always_comb begin
        slot_free = (state_q == EMPTY) || out_ready;
        xfer      = slot_free && gnt_vld && !rst;
        req_ready = (slot_free && !rst) ? grant : '0;
    end

    // Next-state: load on transfer, drain on accept without transfer, otherwise hold.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        case (state_q)
            EMPTY:   if (xfer) state_d = FULL;
            FULL:    if (out_ready && !xfer) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (xfer) begin
            // X/Z on the sampled bit replicates through untouched.
            data_d = {W{req_data[gnt_idx]}};
            id_d   = gnt_idx;
            ptr_d  = gnt_idx;
        end
    end

    // Slot registers; reset discards any pending beat and re-arms requester 0 as first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            ptr_q   <= IW'(N - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_id    = id_q;
    assign busy      = out_valid || (|req_valid);

endmodule

// File: tb/tb_repl_rr_sched.sv
module tb_repl_rr_sched;

    logic clk;
    logic rst;

    // Default instance: N=4, P=2, Q=1 -> W=4
    logic [3:0] rv0, rd0, rr0;
    logic       ov0, ordy0, busy0;
    logic [3:0] od0;
    logic [1:0] oid0;

    // P=1, Q=2 -> W=2
    logic [3:0] rv1, rd1, rr1;
    logic       ov1, ordy1, busy1;
    logic [1:0] od1;
    logic [1:0] oid1;

    // P=2, Q=3 -> W=6
    logic [3:0] rv2, rd2, rr2;
    logic       ov2, ordy2, busy2;
    logic [5:0] od2;
    logic [1:0] oid2;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    repl_rr_sched #(.N(4), .P(2), .Q(1)) u0 (
        .clk(clk), .rst(rst), .req_valid(rv0), .req_data(rd0), .req_ready(rr0),
        .out_valid(ov0), .out_data(od0), .out_id(oid0), .out_ready(ordy0), .busy(busy0)
    );

    repl_rr_sched #(.N(4), .P(1), .Q(2)) u1 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_data(rd1), .req_ready(rr1),
        .out_valid(ov1), .out_data(od1), .out_id(oid1), .out_ready(ordy1), .busy(busy1)
    );

    repl_rr_sched #(.N(4), .P(2), .Q(3)) u2 (
        .clk(clk), .rst(rst), .req_valid(rv2), .req_data(rd2), .req_ready(rr2),
        .out_valid(ov2), .out_data(od2), .out_id(oid2), .out_ready(ordy2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every beat accepted downstream on u0 must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && ov0 && ordy0) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL sb_unexpected: observed beat id=%0d with empty queue", oid0);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_id", 32'(oid0), 32'(e.id));
                chk("sb_data", 32'(od0), 32'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rv0 = 4'b1111; rd0 = 4'b1010; ordy0 = 1'b1;
        rv1 = '0; rd1 = '0; ordy1 = 1'b1;
        rv2 = '0; rd2 = '0; ordy2 = 1'b1;

        // Reset state
        #2;
        chk("rst_out_valid", 32'(ov0), 0);
        chk("rst_out_data", 32'(od0), 0);
        chk("rst_out_id", 32'(oid0), 0);
        chk("rst_req_ready", 32'(rr0), 0);
        chk("rst_busy", 32'(busy0), 1);
        step();
        rst = 1'b0;

        // All four valid, data 1010: grants 0,1,2,3,0 back-to-back
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_grant", 32'(rr0), 32'(1 << (k % 4)));
            if (k == 0) chk("first_latency", 32'(ov0), 0);
            sb.push_back('{id: 2'(k % 4), data: {4{rd0[k % 4]}}});
            step();
        end
        rv0 = 4'b0000;
        step();
        @(negedge clk);
        chk("drain_valid", 32'(ov0), 0);
        chk("drain_id_hold", 32'(oid0), 0);
        chk("drain_busy", 32'(busy0), 0);
        step();

        // X on requester 1, Z on requester 3
        rv0 = 4'b1010;
        rd0 = 4'bz0x0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("xz_grant", 32'(rr0), (k == 0) ? 32'h2 : 32'h8);
            if (k == 0) sb.push_back('{id: 2'd1, data: {4{rd0[1]}}});
            else        sb.push_back('{id: 2'd3, data: {4{rd0[3]}}});
            step();
        end
        rv0 = 4'b0000;
        rd0 = 4'b0000;
        step();
        step();

        // Reset while a beat is stalled; afterwards requester 0 is first again
        rv0 = 4'b0100;
        rd0 = 4'b0100;
        @(negedge clk);
        chk("pre_rst_grant", 32'(rr0), 32'h4);
        step();
        rv0 = 4'b0000;
        ordy0 = 1'b0;
        @(negedge clk);
        chk("stall_valid", 32'(ov0), 1);
        chk("stall_id", 32'(oid0), 2);
        chk("stall_data", 32'(od0), 32'hf);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(ov0), 0);
        chk("async_rst_data", 32'(od0), 0);
        chk("async_rst_id", 32'(oid0), 0);
        rv0 = 4'b1111;
        rd0 = 4'b0001;
        ordy0 = 1'b1;
        #1;
        chk("rst_ready_zero", 32'(rr0), 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_grant", 32'(rr0), 32'h1);
        sb.push_back('{id: 2'd0, data: 4'b1111});
        step();
        rv0 = 4'b0000;
        step();
        step();

        // W=2: requester 2 only, data 1, held for two beats
        rv1 = 4'b0100;
        rd1 = 4'b0100;
        @(negedge clk);
        chk("w2_ready", 32'(rr1), 32'h4);
        chk("w2_valid_before", 32'(ov1), 0);
        step();
        @(negedge clk);
        chk("w2_valid", 32'(ov1), 1);
        chk("w2_data", 32'(od1), 32'h3);
        chk("w2_id", 32'(oid1), 2);
        chk("w2_single_every_beat", 32'(rr1), 32'h4);
        step();
        rv1 = 4'b0000;
        step();
        @(negedge clk);
        chk("w2_drained", 32'(ov1), 0);
        chk("w2_data_hold", 32'(od1), 32'h3);
        chk("w2_id_hold", 32'(oid1), 2);
        chk("w2_busy", 32'(busy1), 0);
        step();

        // W=6: stall 5 cycles with all valid, then release
        rv2 = 4'b1111;
        rd2 = 4'b0011;
        @(negedge clk);
        chk("w6_first_grant", 32'(rr2), 32'h1);
        step();
        ordy2 = 1'b0;
        rd2 = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("w6_stall_ready", 32'(rr2), 0);
            chk("w6_stall_data", 32'(od2), 32'h3f);
            chk("w6_stall_id", 32'(oid2), 0);
            chk("w6_stall_valid", 32'(ov2), 1);
            chk("w6_stall_busy", 32'(busy2), 1);
            step();
        end
        ordy2 = 1'b1;
        @(negedge clk);
        chk("w6_next_grant", 32'(rr2), 32'h2);
        step();
        rv2 = 4'b0000;
        @(negedge clk);
        chk("w6_beat2_valid", 32'(ov2), 1);
        chk("w6_beat2_id", 32'(oid2), 1);
        chk("w6_beat2_data", 32'(od2), 0);
        step();
        @(negedge clk);
        chk("w6_drained", 32'(ov2), 0);
        step();

        chk("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
